// File: rtl/sorted_ram_loader.sv
// -----------------------------------------------------------------------------
// sorted_ram_loader
//
// Upstream stage of the binary search unit. Words arrive over a valid/ready
// handshake and are insertion-sorted into a DEPTH x WORD_SIZE register array.
// On finish, the unfilled entries are padded with all-ones so that the array
// always holds DEPTH non-decreasing entries. done is then raised, and the
// search datapath reads the array through a registered read port.
//
// Optional build macro:
//   SORTED_RAM_LOADER_ASSERT_EN - compiles in simulation assertions
//                                 (the logic is identical with or without it)
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_in_valid  i_in_data is offered
//   i_in_data   word to insert
//   o_in_ready  loader accepts i_in_data this cycle
//   i_finish    pulse: pad the remaining entries and complete
//   i_clear     pulse: abort or restart the load (count <- 0)
//   i_rd_addr   read address from the search datapath
//   o_rd_data   mem[i_rd_addr], registered (1-cycle latency)
//   o_count     number of entries filled, 0..DEPTH
//   o_done      array full and sorted; search may start
//
// FSM states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a word, finish, or a pending finish
//   S_SHIFT | moving larger entries up one slot until x's position is found
//   S_PAD   | writing all-ones into mem[count], one entry per cycle
//   S_DONE  | array full and sorted; held until clear
// -----------------------------------------------------------------------------
module sorted_ram_loader #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    input  logic [WORD_SIZE-1:0] i_in_data,
    output logic                 o_in_ready,
    input  logic                 i_finish,
    input  logic                 i_clear,
    input  logic [ADDR_W-1:0]    i_rd_addr,
    output logic [WORD_SIZE-1:0] o_rd_data,
    output logic [ADDR_W:0]      o_count,
    output logic                 o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   LP_DEPTH  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   LP_CNT1   = 1;
    localparam logic [ADDR_W-1:0] LP_IDX1   = 1;

    state_t                 r_state;
    logic [ADDR_W:0]        r_count;
    logic [ADDR_W-1:0]      r_i;
    logic [WORD_SIZE-1:0]   r_x;
    logic                   r_pend;
    logic                   r_in_ready;
    logic                   r_done;
    logic [WORD_SIZE-1:0]   r_rd_data;
    logic [WORD_SIZE-1:0]   r_mem [DEPTH];

    logic [WORD_SIZE-1:0]   w_prev;
    logic                   w_shift;
    logic [ADDR_W:0]        w_count_inc;
    logic                   w_we;
    logic [ADDR_W-1:0]      w_waddr;
    logic [WORD_SIZE-1:0]   w_wdata;

    // Entry just below the insertion cursor; the shift continues only while
    // it is strictly greater than x, so equal keys stay in arrival order.
    assign w_prev      = r_mem[r_i - LP_IDX1];
    assign w_shift     = (r_i != '0) && (w_prev > r_x);
    assign w_count_inc = r_count + LP_CNT1;

    // Array write port. A clear in the same cycle suppresses the write so an
    // aborted shift or pad does not touch the array on its way out.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_i;
        w_wdata = r_x;
        if (!i_clear) begin
            case (r_state)
                S_SHIFT: begin
                    w_we    = 1'b1;
                    w_waddr = r_i;
                    w_wdata = w_shift ? w_prev : r_x;
                end
                S_PAD: begin
                    w_we    = 1'b1;
                    w_waddr = r_count[ADDR_W-1:0];
                    w_wdata = '1;
                end
                default: ;
            endcase
        end
    end

    // The array itself is not reset.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_i        <= '0;
            r_x        <= '0;
            r_pend     <= 1'b0;
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
            if (i_clear) begin
                r_state    <= S_IDLE;
                r_count    <= '0;
                r_pend     <= 1'b0;
                r_in_ready <= 1'b1;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_in_valid && r_in_ready) begin
                            r_x        <= i_in_data;
                            r_i        <= r_count[ADDR_W-1:0];
                            r_state    <= S_SHIFT;
                            r_in_ready <= 1'b0;
                        end else if (i_finish || r_pend) begin
                            r_pend     <= 1'b0;
                            r_in_ready <= 1'b0;
                            if (r_count == LP_DEPTH) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_PAD;
                            end
                        end else begin
                            r_in_ready <= (r_count < LP_DEPTH);
                        end
                    end
                    S_SHIFT: begin
                        if (i_finish) begin
                            r_pend <= 1'b1;
                        end
                        if (w_shift) begin
                            r_i <= r_i - LP_IDX1;
                        end else begin
                            r_count <= w_count_inc;
                            if (w_count_inc == LP_DEPTH) begin
                                // A finish that arrived during this shift has
                                // nothing left to do once the array is full.
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_pend  <= 1'b0;
                            end else begin
                                r_state    <= S_IDLE;
                                r_in_ready <= 1'b1;
                            end
                        end
                    end
                    S_PAD: begin
                        r_count <= w_count_inc;
                        if (w_count_inc == LP_DEPTH) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_in_ready <= 1'b0;
                        r_done     <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_rd_data  = r_rd_data;
    assign o_count    = r_count;
    assign o_done     = r_done;

`ifdef SORTED_RAM_LOADER_ASSERT_EN
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            if (r_state != S_IDLE) begin
                assert (r_in_ready == 1'b0)
                    else $error("in_ready high outside IDLE");
            end
            assert (r_count <= LP_DEPTH)
                else $error("count exceeds DEPTH");
            assert (!(i_clear && (r_state == S_IDLE) && i_in_valid && r_in_ready &&
                      (r_state_next_is_shift(i_clear))))
                else $error("clear and accept in the same cycle");
            if (r_state == S_DONE) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    assert (r_mem[k] <= r_mem[k+1])
                        else $error("array not sorted at %0d", k);
                end
            end
        end
    end

    // An accept only takes effect when no clear is present.
    function automatic logic r_state_next_is_shift(input logic clr);
        return !clr;
    endfunction
`endif

endmodule

// File: tb/tb_sorted_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_sorted_ram_loader
//
// Directed bench for sorted_ram_loader. Inputs are driven and outputs sampled
// 1 ns after the rising edge. Expected values are hand-computed per scenario.
// -----------------------------------------------------------------------------
module tb_sorted_ram_loader;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       finish;
    logic       clear;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [5:0] count;
    logic       done;

    int n_cmp;
    int n_err;

    sorted_ram_loader #(
        .WORD_SIZE(8),
        .DEPTH    (32),
        .ADDR_W   (5)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_in_valid(in_valid),
        .i_in_data (in_data),
        .o_in_ready(in_ready),
        .i_finish  (finish),
        .i_clear   (clear),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .o_count   (count),
        .o_done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one word, then counts cycles from the accept edge until the
    // loader is back in IDLE (in_ready) or full (done). -1 means timeout.
    task automatic insert(input logic [7:0] v, output int cyc);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!in_ready && !done && cyc < 200) begin
            tick();
            cyc++;
        end
        if (cyc >= 200) cyc = -1;
    endtask

    task automatic read_mem(input logic [4:0] a, output logic [7:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        n_cmp++;
        if (count !== 6'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", count);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_rd_data: got %h want 00", rd_data);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_insert_pad();
        int         cyc;
        logic [7:0] d;
        logic [7:0] exp_v [3];
        int         exp_c [3];
        logic [7:0] vals  [3];
        vals  = '{8'd30, 8'd10, 8'd20};
        exp_c = '{1, 2, 2};
        exp_v = '{8'd10, 8'd20, 8'd30};
        for (int k = 0; k < 3; k++) begin
            insert(vals[k], cyc);
            n_cmp++;
            if (cyc != exp_c[k]) begin
                n_err++;
                $display("FAIL insert_cycles[%0d]: got %0d want %0d", k, cyc, exp_c[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            read_mem(5'(k), d);
            n_cmp++;
            if (d !== exp_v[k]) begin
                n_err++;
                $display("FAIL sorted_mem[%0d]: got %0d want %0d", k, d, exp_v[k]);
            end
        end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != 29) begin
            n_err++;
            $display("FAIL pad_cycles: got %0d want 29", cyc);
        end
        n_cmp++;
        if (count !== 6'd32) begin
            n_err++;
            $display("FAIL pad_count: got %0d want 32", count);
        end
        read_mem(5'd3, d);
        n_cmp++;
        if (d !== 8'hFF) begin
            n_err++;
            $display("FAIL pad_mem3: got %h want ff", d);
        end
        read_mem(5'd31, d);
        n_cmp++;
        if (d !== 8'hFF) begin
            n_err++;
            $display("FAIL pad_mem31: got %h want ff", d);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL done_in_ready: got %b want 0", in_ready);
        end
        pulse_clear();
        n_cmp++;
        if (done !== 1'b0 || count !== 6'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL clear_from_done: got done=%b count=%0d rdy=%b want 0/0/1",
                     done, count, in_ready);
        end
    endtask

    task automatic test_descending();
        int         cyc;
        logic [7:0] d;
        for (int n = 0; n < 32; n++) begin
            insert(8'(31 - n), cyc);
            n_cmp++;
            if (cyc != n + 1) begin
                n_err++;
                $display("FAIL desc_cycles[n=%0d]: got %0d want %0d", n, cyc, n + 1);
            end
        end
        n_cmp++;
        if (done !== 1'b1 || count !== 6'd32) begin
            n_err++;
            $display("FAIL desc_done: got done=%b count=%0d want 1/32", done, count);
        end
        for (int k = 0; k < 32; k++) begin
            read_mem(5'(k), d);
            n_cmp++;
            if (d !== 8'(k)) begin
                n_err++;
                $display("FAIL desc_mem[%0d]: got %0d want %0d", k, d, k);
            end
        end
        pulse_clear();
    endtask

    task automatic test_duplicates();
        int         cyc;
        logic [7:0] d;
        logic [7:0] exp_v [4];
        int         exp_c [4];
        logic [7:0] vals  [4];
        vals  = '{8'd5, 8'd5, 8'd5, 8'd4};
        exp_c = '{1, 1, 1, 4};
        exp_v = '{8'd4, 8'd5, 8'd5, 8'd5};
        for (int k = 0; k < 4; k++) begin
            insert(vals[k], cyc);
            n_cmp++;
            if (cyc != exp_c[k]) begin
                n_err++;
                $display("FAIL dup_cycles[%0d]: got %0d want %0d", k, cyc, exp_c[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            read_mem(5'(k), d);
            n_cmp++;
            if (d !== exp_v[k]) begin
                n_err++;
                $display("FAIL dup_mem[%0d]: got %0d want %0d", k, d, exp_v[k]);
            end
        end
        n_cmp++;
        if (count !== 6'd4) begin
            n_err++;
            $display("FAIL dup_count: got %0d want 4", count);
        end
        pulse_clear();
    endtask

    task automatic test_pending_finish();
        int         cyc;
        int         rdy_seen;
        logic [7:0] d;
        for (int k = 0; k < 10; k++) begin
            insert(8'(2 * k), cyc);
        end
        n_cmp++;
        if (count !== 6'd10) begin
            n_err++;
            $display("FAIL pend_setup_count: got %0d want 10", count);
        end
        // 7 lands at position 4: 6 shifts + 1 write, one IDLE cycle, 21 pads.
        in_valid = 1'b1;
        in_data  = 8'd7;
        tick();
        in_valid = 1'b0;
        finish   = 1'b1;
        tick();
        finish   = 1'b0;
        cyc      = 1;
        rdy_seen = -1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
            if (in_ready && rdy_seen < 0) rdy_seen = cyc;
        end
        n_cmp++;
        if (rdy_seen != 7) begin
            n_err++;
            $display("FAIL pend_idle_cycle: got %0d want 7", rdy_seen);
        end
        n_cmp++;
        if (cyc != 29) begin
            n_err++;
            $display("FAIL pend_done_cycles: got %0d want 29", cyc);
        end
        n_cmp++;
        if (count !== 6'd32) begin
            n_err++;
            $display("FAIL pend_count: got %0d want 32", count);
        end
        read_mem(5'd4, d);
        n_cmp++;
        if (d !== 8'd7) begin
            n_err++;
            $display("FAIL pend_mem4: got %0d want 7", d);
        end
        read_mem(5'd5, d);
        n_cmp++;
        if (d !== 8'd8) begin
            n_err++;
            $display("FAIL pend_mem5: got %0d want 8", d);
        end
        read_mem(5'd10, d);
        n_cmp++;
        if (d !== 8'd18) begin
            n_err++;
            $display("FAIL pend_mem10: got %0d want 18", d);
        end
        read_mem(5'd11, d);
        n_cmp++;
        if (d !== 8'hFF) begin
            n_err++;
            $display("FAIL pend_mem11: got %h want ff", d);
        end
        pulse_clear();
    endtask

    task automatic test_clear_mid_shift();
        int         cyc;
        logic [7:0] d;
        insert(8'd10, cyc);
        insert(8'd20, cyc);
        insert(8'd30, cyc);
        in_valid = 1'b1;
        in_data  = 8'd5;
        tick();
        in_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (count !== 6'd0 || in_ready !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL clear_mid_shift: got count=%0d rdy=%b done=%b want 0/1/0",
                     count, in_ready, done);
        end
        insert(8'd9, cyc);
        n_cmp++;
        if (cyc != 1) begin
            n_err++;
            $display("FAIL clear_reinsert_cycles: got %0d want 1", cyc);
        end
        read_mem(5'd0, d);
        n_cmp++;
        if (d !== 8'd9) begin
            n_err++;
            $display("FAIL clear_reinsert_mem0: got %0d want 9", d);
        end
        n_cmp++;
        if (count !== 6'd1) begin
            n_err++;
            $display("FAIL clear_reinsert_count: got %0d want 1", count);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        finish   = 1'b0;
        clear    = 1'b0;
        rd_addr  = 5'd0;
        test_reset();
        test_insert_pad();
        test_descending();
        test_duplicates();
        test_pending_finish();
        test_clear_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
